// File: rtl/llmint8_outlier_detector.sv
// Streaming outlier detector for the int8/high-precision split: flags elements whose magnitude
// exceeds a per-tile threshold and summarises flagged columns and count per DEPTH-row tile.
module llmint8_outlier_detector #(
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned IN_FRAC_WIDTH = 0,
  parameter int unsigned PARALLELISM   = 4,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned THRES_WIDTH   = IN_WIDTH - IN_FRAC_WIDTH,
  parameter int unsigned CNT_WIDTH     = $clog2(PARALLELISM * DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [THRES_WIDTH-1:0] threshold,
  input  logic [IN_WIDTH-1:0]    data_in [PARALLELISM],
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic [IN_WIDTH-1:0]    data_out [PARALLELISM],
  output logic [PARALLELISM-1:0] row_mask,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic [PARALLELISM-1:0] col_mask,
  output logic [CNT_WIDTH-1:0]   outlier_count,
  output logic                   col_mask_valid,
  input  logic                   col_mask_ready
);

  localparam int unsigned SCALED_W = THRES_WIDTH + IN_FRAC_WIDTH;
  localparam int unsigned CMP_W    = ((IN_WIDTH > SCALED_W) ? IN_WIDTH : SCALED_W) + 1;
  localparam int unsigned ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (IN_WIDTH <= IN_FRAC_WIDTH + 1) begin : g_bad_width
      $fatal(1, "llmint8_outlier_detector: IN_WIDTH - IN_FRAC_WIDTH must exceed 1");
    end
  endgenerate

  logic [ROW_W-1:0]       row_cnt;
  logic [PARALLELISM-1:0] acc;
  logic [CNT_WIDTH-1:0]   cnt_acc;
  logic [THRES_WIDTH-1:0] thr_lat;
  logic [THRES_WIDTH-1:0] thr_use;
  logic [CMP_W-1:0]       thr_scaled;
  logic [PARALLELISM-1:0] flags;
  logic [CNT_WIDTH-1:0]   flag_cnt;
  logic [IN_WIDTH-1:0]    mag;
  logic                   accept;
  logic                   last_row;

  assign data_in_ready = (!data_out_valid || data_out_ready) && !(col_mask_valid && !col_mask_ready);
  assign accept        = data_in_valid && data_in_ready;
  assign last_row      = (row_cnt == ROW_W'(DEPTH - 1));

  // Row 0 of a tile sees the live threshold; later rows use the value latched at row 0.
  always_comb begin
    thr_use    = (row_cnt == '0) ? threshold : thr_lat;
    thr_scaled = CMP_W'(thr_use) << IN_FRAC_WIDTH;
    flags      = '0;
    flag_cnt   = '0;
    mag        = '0;
    for (int unsigned i = 0; i < PARALLELISM; i++) begin
      // Negation of the most negative value yields 2^(IN_WIDTH-1) as an unsigned magnitude.
      mag      = data_in[i][IN_WIDTH-1] ? (~data_in[i] + IN_WIDTH'(1)) : data_in[i];
      flags[i] = (CMP_W'(mag) > thr_scaled);
      flag_cnt = flag_cnt + CNT_WIDTH'(flags[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt        <= '0;
      acc            <= '0;
      cnt_acc        <= '0;
      thr_lat        <= '0;
      data_out_valid <= 1'b0;
      row_mask       <= '0;
      col_mask_valid <= 1'b0;
      col_mask       <= '0;
      outlier_count  <= '0;
      for (int unsigned i = 0; i < PARALLELISM; i++) data_out[i] <= '0;
    end else begin
      if (accept) begin
        data_out_valid <= 1'b1;
        row_mask       <= flags;
        for (int unsigned i = 0; i < PARALLELISM; i++) data_out[i] <= data_in[i];
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end

      if (accept && row_cnt == '0) thr_lat <= threshold;

      if (accept && last_row) begin
        col_mask       <= acc | flags;
        outlier_count  <= cnt_acc + flag_cnt;
        col_mask_valid <= 1'b1;
        acc            <= '0;
        cnt_acc        <= '0;
        row_cnt        <= '0;
      end else begin
        if (col_mask_ready) col_mask_valid <= 1'b0;
        if (accept) begin
          acc     <= acc | flags;
          cnt_acc <= cnt_acc + flag_cnt;
          row_cnt <= row_cnt + ROW_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_llmint8_outlier_detector.sv
// Directed bench for llmint8_outlier_detector: boundary flags, tile summaries,
// backpressure on both outputs, threshold latching and mid-tile reset.
module tb_llmint8_outlier_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] thr;
  logic [15:0] din [4];
  logic        vin;
  logic        din_ready;
  logic [15:0] dout [4];
  logic [3:0]  rmask;
  logic        dov;
  logic        dor;
  logic [3:0]  cmask;
  logic [4:0]  ocnt;
  logic        cmv;
  logic        cmr;

  logic [7:0]  fthr;
  logic [15:0] fdin [2];
  logic        fvin;
  logic        f_ready;
  logic [15:0] fdout [2];
  logic [1:0]  f_rmask;
  logic        f_dov;
  logic [1:0]  f_cmask;
  logic [1:0]  f_cnt;
  logic        f_cmv;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  llmint8_outlier_detector #(
    .IN_WIDTH(16), .IN_FRAC_WIDTH(0), .PARALLELISM(4), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .threshold(thr),
    .data_in(din), .data_in_valid(vin), .data_in_ready(din_ready),
    .data_out(dout), .row_mask(rmask), .data_out_valid(dov), .data_out_ready(dor),
    .col_mask(cmask), .outlier_count(ocnt), .col_mask_valid(cmv), .col_mask_ready(cmr)
  );

  llmint8_outlier_detector #(
    .IN_WIDTH(16), .IN_FRAC_WIDTH(8), .PARALLELISM(2), .DEPTH(1)
  ) dut_f (
    .clk(clk), .rst(rst), .threshold(fthr),
    .data_in(fdin), .data_in_valid(fvin), .data_in_ready(f_ready),
    .data_out(fdout), .row_mask(f_rmask), .data_out_valid(f_dov), .data_out_ready(1'b1),
    .col_mask(f_cmask), .outlier_count(f_cnt), .col_mask_valid(f_cmv), .col_mask_ready(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int a, input int b, input int c, input int d);
    din[0] = 16'(a);
    din[1] = 16'(b);
    din[2] = 16'(c);
    din[3] = 16'(d);
  endtask

  initial begin
    rst = 1'b1; thr = '0; vin = 1'b0; dor = 1'b1; cmr = 1'b1;
    fthr = '0; fvin = 1'b0; fdin[0] = '0; fdin[1] = '0;
    set_row(0, 0, 0, 0);
    #1;
    chk("rst_dov", dov, 0);
    chk("rst_cmv", cmv, 0);
    chk("rst_dout0", dout[0], 0);
    chk("rst_rmask", rmask, 0);
    chk("rst_cmask", cmask, 0);
    chk("rst_cnt", ocnt, 0);
    tick(); tick();
    rst = 1'b0;
    #1 chk("rst_ready", din_ready, 1);

    // Boundaries around threshold 127
    thr = 16'd127; vin = 1'b1; set_row(127, 128, -127, -128);
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("t1_dov", dov, 1);
      chk("t1_rmask", rmask, 4'b1010);
      chk("t1_cmv", cmv, (r == 3));
    end
    chk("t1_cmask", cmask, 4'b1010);
    chk("t1_cnt", ocnt, 8);
    chk("t1_dout1", dout[1], 16'd128);
    chk("t1_dout3", dout[3], 16'hFF80);
    vin = 1'b0;
    tick();
    chk("t1_dov_drop", dov, 0);
    chk("t1_cmv_drop", cmv, 0);

    // Most negative value, plus fractional instance
    thr = 16'd32767; vin = 1'b1; set_row(-32768, 32767, -32767, 0);
    fthr = 8'd1; fvin = 1'b1; fdin[0] = 16'h0100; fdin[1] = 16'h0101;
    tick();
    chk("t2_rmask", rmask, 4'b0001);
    chk("t2f_rmask", f_rmask, 2'b10);
    chk("t2f_cmv", f_cmv, 1);
    chk("t2f_cmask", f_cmask, 2'b10);
    chk("t2f_cnt", f_cnt, 1);
    fvin = 1'b0;
    set_row(0, 0, 0, 0);
    tick(); tick(); tick();
    chk("t2_cmv", cmv, 1);
    chk("t2_cmask", cmask, 4'b0001);
    chk("t2_cnt", ocnt, 1);
    vin = 1'b0;
    tick();

    // Sparse outliers across a tile
    thr = 16'd127; vin = 1'b1; set_row(300, 0, 0, 0);
    tick();
    chk("t3_rmask0", rmask, 4'b0001);
    set_row(0, 0, 0, 0);
    tick(); tick();
    chk("t3_cmv_early", cmv, 0);
    set_row(0, 0, -200, 0);
    tick();
    chk("t3_rmask3", rmask, 4'b0100);
    chk("t3_dov", dov, 1);
    chk("t3_cmv", cmv, 1);
    chk("t3_cmask", cmask, 4'b0101);
    chk("t3_cnt", ocnt, 2);
    vin = 1'b0;
    tick();

    // Row output backpressure
    dor = 1'b0; vin = 1'b1; set_row(1000, 0, 0, 0);
    tick();
    set_row(0, 1000, 0, 0);
    for (int r = 0; r < 3; r++) begin
      chk("t4_ready", din_ready, 0);
      tick();
      chk("t4_dov", dov, 1);
      chk("t4_dout0", dout[0], 16'd1000);
      chk("t4_dout1", dout[1], 16'd0);
      chk("t4_rmask", rmask, 4'b0001);
    end
    dor = 1'b1;
    #1 chk("t4_ready_rel", din_ready, 1);
    tick();
    chk("t4_dout1_b", dout[1], 16'd1000);
    chk("t4_rmask_b", rmask, 4'b0010);
    set_row(0, 0, 0, 0);
    tick(); tick();
    chk("t4_cmv", cmv, 1);
    chk("t4_cmask", cmask, 4'b0011);
    chk("t4_cnt", ocnt, 2);
    vin = 1'b0;
    tick();
    chk("t4_dov_drop", dov, 0);

    // Summary backpressure
    cmr = 1'b0; vin = 1'b1; set_row(0, 0, 0, 500);
    tick(); tick(); tick(); tick();
    chk("t5_cmv", cmv, 1);
    chk("t5_cmask", cmask, 4'b1000);
    chk("t5_cnt", ocnt, 4);
    chk("t5_ready", din_ready, 0);
    set_row(500, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("t5_dov_stall", dov, 0);
      chk("t5_cmv_hold", cmv, 1);
      chk("t5_cmask_hold", cmask, 4'b1000);
      chk("t5_ready_stall", din_ready, 0);
    end
    cmr = 1'b1;
    #1 chk("t5_ready_rel", din_ready, 1);
    tick();
    chk("t5_cmv_drain", cmv, 0);
    chk("t5_dov", dov, 1);
    chk("t5_rmask", rmask, 4'b0001);
    chk("t5_dout0", dout[0], 16'd500);
    set_row(0, 0, 0, 0);
    tick(); tick(); tick();
    chk("t5_cmv2", cmv, 1);
    chk("t5_cmask2", cmask, 4'b0001);
    chk("t5_cnt2", ocnt, 1);
    vin = 1'b0;
    tick();

    // Threshold latched at row 0
    thr = 16'd127; vin = 1'b1; set_row(50, 50, 50, 50);
    tick();
    chk("t6_rmask0", rmask, 4'b0000);
    thr = 16'd0;
    tick();
    chk("t6_rmask1", rmask, 4'b0000);
    tick(); tick();
    chk("t6_cmv", cmv, 1);
    chk("t6_cmask", cmask, 4'b0000);
    chk("t6_cnt", ocnt, 0);
    vin = 1'b0;
    tick();

    // Mid-tile reset discards partial tile
    thr = 16'd0; vin = 1'b1;
    tick();
    chk("t6b_rmask", rmask, 4'b1111);
    tick();
    vin = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6b_dov", dov, 0);
    chk("t6b_rmask_rst", rmask, 0);
    chk("t6b_dout0", dout[0], 0);
    chk("t6b_cmv", cmv, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    thr = 16'd127; vin = 1'b1; set_row(200, 0, 0, 0);
    tick();
    chk("t6b_rmask0", rmask, 4'b0001);
    chk("t6b_cmv0", cmv, 0);
    set_row(0, 0, 0, 0);
    tick();
    chk("t6b_cmv1", cmv, 0);
    tick(); tick();
    chk("t6b_cmv_end", cmv, 1);
    chk("t6b_cmask", cmask, 4'b0001);
    chk("t6b_cnt", ocnt, 1);
    vin = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
